// File: rtl/scan_code_ctrl.sv
// PS/2 scan-code sequencer with a first-word fall-through character FIFO.
// Optional shift-key tracking is enabled by defining SCAN_CODE_SHIFT_TRACK_EN.
module scan_code_ctrl #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [7:0]  BREAK_CODE = 8'hF0,
    parameter logic [7:0]  EXT_CODE   = 8'hE0
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          NewScanCode,
    input  logic [7:0]                    ScanCode,
    input  logic                          NewAscii,
    input  logic [7:0]                    Ascii,
    output logic                          LoadDato,
    output logic                          ScanCodeType,
    output logic                          LoadChar,
    output logic                          Extended,
    output logic [8:0]                    CharData,
    input  logic                          CharRead,
    output logic                          Empty,
    output logic                          Full,
    output logic                          Overflow,
    output logic [$clog2(FIFO_DEPTH):0]   Count,
    output logic                          Shift
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {SLEEP, RECEIVED, TYPE, NEW, BRK, EXT} state_t;

    state_t     state;
    logic [8:0] char_word;

    // Sequencer; strobes are registered so they follow the state exactly
    always_ff @(negedge Clock) begin
        if (Reset) begin
            state        <= SLEEP;
            LoadDato     <= 1'b0;
            ScanCodeType <= 1'b0;
            LoadChar     <= 1'b0;
            Extended     <= 1'b0;
            char_word    <= '0;
        end else begin
            LoadDato     <= 1'b0;
            ScanCodeType <= 1'b0;
            LoadChar     <= 1'b0;
            case (state)
                SLEEP, EXT: begin
                    if (NewScanCode) begin
                        if (ScanCode == BREAK_CODE) begin
                            state <= BRK;
                        end else if (ScanCode == EXT_CODE && state == SLEEP) begin
                            state    <= EXT;
                            Extended <= 1'b1;
                        end else begin
                            state    <= RECEIVED;
                            LoadDato <= 1'b1;
                        end
                    end
                end
                RECEIVED: begin
                    state        <= TYPE;
                    ScanCodeType <= 1'b1;
                end
                TYPE: begin
                    if (NewAscii) begin
                        state     <= NEW;
                        LoadChar  <= 1'b1;
                        char_word <= {Extended, Ascii};
                    end else begin
                        state    <= SLEEP;
                        Extended <= 1'b0;
                    end
                end
                NEW: begin
                    state    <= SLEEP;
                    Extended <= 1'b0;
                end
                BRK: begin
                    if (NewScanCode) begin
                        state    <= SLEEP;
                        Extended <= 1'b0;
                    end
                end
                default: state <= SLEEP;
            endcase
        end
    end

`ifdef SCAN_CODE_SHIFT_TRACK_EN
    localparam logic [7:0] LSHIFT_CODE = 8'h12;
    localparam logic [7:0] RSHIFT_CODE = 8'h59;

    logic shift_l;
    logic shift_r;
    logic make_slot;

    always_comb make_slot = (state == SLEEP) || (state == EXT);

    // Each side tracked separately so releasing one shift keeps the other held
    always_ff @(negedge Clock) begin
        if (Reset) begin
            shift_l <= 1'b0;
            shift_r <= 1'b0;
            Shift   <= 1'b0;
        end else if (NewScanCode) begin
            if (make_slot && ScanCode == LSHIFT_CODE) begin
                shift_l <= 1'b1;
                Shift   <= 1'b1;
            end else if (make_slot && ScanCode == RSHIFT_CODE) begin
                shift_r <= 1'b1;
                Shift   <= 1'b1;
            end else if (state == BRK && ScanCode == LSHIFT_CODE) begin
                shift_l <= 1'b0;
                Shift   <= shift_r;
            end else if (state == BRK && ScanCode == RSHIFT_CODE) begin
                shift_r <= 1'b0;
                Shift   <= shift_l;
            end
        end
    end
`else
    assign Shift = 1'b0;
`endif

    logic [8:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_nx;
    logic [PTR_W-1:0] rd_ptr_nx;
    logic [CNT_W-1:0] count_nx;
    logic [8:0]       head_nx;
    logic             do_push;
    logic             do_pop;

    // FIFO next-state; a push into a full FIFO succeeds only alongside a pop
    always_comb begin
        do_pop    = CharRead && !Empty;
        do_push   = LoadChar && (!Full || do_pop);
        wr_ptr_nx = do_push ? wr_ptr + PTR_W'(1) : wr_ptr;
        rd_ptr_nx = do_pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_nx  = Count;
        if (do_push && !do_pop) count_nx = Count + CNT_W'(1);
        if (do_pop && !do_push) count_nx = Count - CNT_W'(1);
        head_nx   = (do_push && rd_ptr_nx == wr_ptr) ? char_word : mem[rd_ptr_nx];
    end

    always_ff @(negedge Clock) begin
        if (do_push && !Reset) mem[wr_ptr] <= char_word;
    end

    always_ff @(negedge Clock) begin
        if (Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            Count    <= '0;
            Empty    <= 1'b1;
            Full     <= 1'b0;
            Overflow <= 1'b0;
            CharData <= '0;
        end else begin
            wr_ptr   <= wr_ptr_nx;
            rd_ptr   <= rd_ptr_nx;
            Count    <= count_nx;
            Empty    <= (count_nx == '0);
            Full     <= (count_nx == CNT_W'(FIFO_DEPTH));
            CharData <= head_nx;
            if (LoadChar && Full && !do_pop) Overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_scan_code_ctrl.sv
// Scoreboard bench for scan_code_ctrl: expected FIFO words are queued at stimulus
// time and compared when popped. Works with or without SCAN_CODE_SHIFT_TRACK_EN.
module tb_scan_code_ctrl;

    localparam int unsigned DEPTH = 8;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       NewScanCode;
    logic [7:0] ScanCode;
    logic       NewAscii;
    logic [7:0] Ascii;
    logic       LoadDato;
    logic       ScanCodeType;
    logic       LoadChar;
    logic       Extended;
    logic [8:0] CharData;
    logic       CharRead;
    logic       Empty;
    logic       Full;
    logic       Overflow;
    logic [3:0] Count;
    logic       Shift;

    int         errors = 0;
    int         checks = 0;
    logic [8:0] sb[$];
    logic       ovf_m = 1'b0;
    logic       sh_l = 1'b0;
    logic       sh_r = 1'b0;

    scan_code_ctrl #(.FIFO_DEPTH(DEPTH), .BREAK_CODE(8'hF0), .EXT_CODE(8'hE0)) dut (
        .Clock(Clock), .Reset(Reset), .NewScanCode(NewScanCode), .ScanCode(ScanCode),
        .NewAscii(NewAscii), .Ascii(Ascii), .LoadDato(LoadDato), .ScanCodeType(ScanCodeType),
        .LoadChar(LoadChar), .Extended(Extended), .CharData(CharData), .CharRead(CharRead),
        .Empty(Empty), .Full(Full), .Overflow(Overflow), .Count(Count), .Shift(Shift)
    );

    // DUT updates on the falling edge; the bench samples and drives on the rising edge
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_count"}, 32'(Count), 32'(sb.size()));
        chk({tag, "_empty"}, 32'(Empty), 32'(sb.size() == 0));
        chk({tag, "_full"}, 32'(Full), 32'(sb.size() == DEPTH));
        chk({tag, "_ovf"}, 32'(Overflow), 32'(ovf_m));
        chk({tag, "_shift"}, 32'(Shift), 32'(sh_l | sh_r));
    endtask

    task automatic strobe(input logic [7:0] b);
        ScanCode    = b;
        NewScanCode = 1'b1;
        @(posedge Clock);
        NewScanCode = 1'b0;
    endtask

    task automatic shift_make(input logic [7:0] code);
`ifdef SCAN_CODE_SHIFT_TRACK_EN
        if (code == 8'h12) sh_l = 1'b1;
        if (code == 8'h59) sh_r = 1'b1;
`else
        if (code == 8'h00) sh_l = 1'b0;
`endif
    endtask

    task automatic shift_break(input logic [7:0] code);
`ifdef SCAN_CODE_SHIFT_TRACK_EN
        if (code == 8'h12) sh_l = 1'b0;
        if (code == 8'h59) sh_r = 1'b0;
`else
        if (code == 8'h00) sh_l = 1'b0;
`endif
    endtask

    // Full make sequence with per-cycle strobe checks; optional pop during NEW
    // and optional stray strobes while RECEIVED/TYPE/NEW
    task automatic make_key(input logic [7:0] code, input logic ext, input logic hit,
                            input logic [7:0] asc, input logic pop_in_new, input logic junk);
        NewAscii = hit;
        Ascii    = asc;
        if (ext) begin
            strobe(8'hE0);
            chk("ext_set", 32'(Extended), 1);
            chk("ext_noload", 32'(LoadDato), 0);
        end
        strobe(code);
        shift_make(code);
        chk("load_dato", 32'(LoadDato), 1);
        chk("type_early", 32'(ScanCodeType), 0);
        if (junk) begin
            ScanCode    = 8'hF0;
            NewScanCode = 1'b1;
        end
        @(posedge Clock);
        chk("scan_type", 32'(ScanCodeType), 1);
        chk("load_dato_once", 32'(LoadDato), 0);
        chk("ext_in_type", 32'(Extended), 32'(ext));
        @(posedge Clock);
        chk("load_char", 32'(LoadChar), 32'(hit));
        chk("type_once", 32'(ScanCodeType), 0);
        if (hit) begin
            if (pop_in_new && sb.size() > 0) begin
                chk("head_at_push", 32'(CharData), 32'(sb[0]));
                void'(sb.pop_front());
                CharRead = 1'b1;
            end
            if (sb.size() < DEPTH) sb.push_back({ext, asc});
            else ovf_m = 1'b1;
        end
        @(posedge Clock);
        NewScanCode = 1'b0;
        CharRead    = 1'b0;
        chk("load_char_once", 32'(LoadChar), 0);
        chk("ext_cleared", 32'(Extended), 0);
        check_status("make");
    endtask

    task automatic brk_seq(input logic ext, input logic [7:0] code);
        if (ext) begin
            strobe(8'hE0);
            chk("brk_ext_set", 32'(Extended), 1);
        end
        strobe(8'hF0);
        chk("brk_noload", 32'(LoadDato), 0);
        strobe(code);
        shift_break(code);
        chk("brk_discard", 32'(LoadDato), 0);
        chk("brk_ext_clr", 32'(Extended), 0);
        @(posedge Clock);
        chk("brk_notype", 32'(ScanCodeType), 0);
        chk("brk_nopush", 32'(LoadChar), 0);
        check_status("brk");
    endtask

    task automatic pop_char();
        if (sb.size() > 0) begin
            chk("head", 32'(CharData), 32'(sb[0]));
            void'(sb.pop_front());
        end
        CharRead = 1'b1;
        @(posedge Clock);
        CharRead = 1'b0;
        check_status("pop");
    endtask

    initial begin
        Reset       = 1'b1;
        NewScanCode = 1'b0;
        ScanCode    = 8'h00;
        NewAscii    = 1'b0;
        Ascii       = 8'h00;
        CharRead    = 1'b0;
        repeat (3) @(posedge Clock);
        chk("rst_load_dato", 32'(LoadDato), 0);
        chk("rst_scan_type", 32'(ScanCodeType), 0);
        chk("rst_load_char", 32'(LoadChar), 0);
        chk("rst_extended", 32'(Extended), 0);
        check_status("rst");
        Reset = 1'b0;

        // basic make: latency 1/2/3, head 9'h061
        make_key(8'h1C, 1'b0, 1'b1, 8'h61, 1'b0, 1'b0);
        chk("first_word", 32'(CharData), 32'h061);
        pop_char();

        // break of an ordinary key, then back in SLEEP
        brk_seq(1'b0, 8'h1C);
        make_key(8'h1C, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // extended make and extended break
        make_key(8'h75, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0);
        chk("ext_word", 32'(CharData), 32'h180);
        pop_char();
        brk_seq(1'b1, 8'h75);

        // lookup miss with extended prefix, and stray strobes while busy
        make_key(8'h6B, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
        make_key(8'h2A, 1'b0, 1'b1, 8'h76, 1'b0, 1'b1);
        make_key(8'h1B, 1'b0, 1'b1, 8'h73, 1'b0, 1'b0);
        pop_char();
        pop_char();

        // overflow: nine pushes into an 8-deep FIFO
        for (int i = 0; i < 9; i++)
            make_key(8'h16 + 8'(i), 1'b0, 1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
        chk("ovf_full", 32'(Full), 1);
        chk("ovf_sticky", 32'(Overflow), 1);
        make_key(8'h4D, 1'b1, 1'b1, 8'h70, 1'b1, 1'b0);
        chk("full_pushpop_cnt", 32'(Count), 8);
        for (int i = 0; i < 8; i++) pop_char();
        pop_char();

        // shift keys: ordinary codes without the macro, tracked with it
        make_key(8'h12, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        pop_char();
        make_key(8'h59, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        brk_seq(1'b0, 8'h12);
        brk_seq(1'b0, 8'h59);
        make_key(8'h59, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // reset in TYPE with a lookup hit pending
        NewAscii = 1'b1;
        Ascii    = 8'h41;
        strobe(8'h1C);
        @(posedge Clock);
        chk("pre_rst_type", 32'(ScanCodeType), 1);
        Reset = 1'b1;
        @(posedge Clock);
        Reset = 1'b0;
        sb.delete();
        ovf_m = 1'b0;
        sh_l  = 1'b0;
        sh_r  = 1'b0;
        chk("midrst_load_char", 32'(LoadChar), 0);
        chk("midrst_scan_type", 32'(ScanCodeType), 0);
        check_status("midrst");
        @(posedge Clock);
        chk("midrst_no_push", 32'(Empty), 1);
        make_key(8'h24, 1'b0, 1'b1, 8'h65, 1'b0, 1'b0);
        pop_char();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scan_code_ctrl.md
SCAN_CODE_CTRL -- requirements
Module: scan_code_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, character FIFO depth; power of two, 2..64.
REQ-002 SHALL have parameter BREAK_CODE, default 8'hF0, key-release prefix byte.
REQ-003 SHALL have parameter EXT_CODE, default 8'hE0, extended-key prefix byte.
REQ-004 SHALL have port Clock  input  1  single clock; one clock, all state updates on falling edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port NewScanCode  input  1  one-cycle strobe, ScanCode valid.
REQ-007 SHALL have port ScanCode  input  8  received PS/2 byte.
REQ-008 SHALL have port NewAscii  input  1  lookup hit, sampled in TYPE only.
REQ-009 SHALL have port Ascii  input  8  lookup result, sampled in TYPE only.
REQ-010 SHALL have port LoadDato  output  1  load scan-code register; high in RECEIVED.
REQ-011 SHALL have port ScanCodeType  output  1  lookup enable; high in TYPE.
REQ-012 SHALL have port LoadChar  output  1  FIFO push strobe; high in NEW.
REQ-013 SHALL have port Extended  output  1  current code followed EXT_CODE.
REQ-014 SHALL have port CharData  output  9  FIFO head {ext, ascii}, first-word fall-through.
REQ-015 SHALL have port CharRead  input  1  pop request.
REQ-016 SHALL have ports Empty, Full, Overflow  output  1 each  FIFO status.
REQ-017 SHALL have port Count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-018 SHALL have port Shift  output  1  shift-key level (see Configuration).

Function
REQ-019 SHALL implement states SLEEP, RECEIVED, TYPE, NEW, BRK, EXT; outputs decoded from state only.
REQ-020 SLEEP: NewScanCode & ScanCode==BREAK_CODE -> BRK; ==EXT_CODE -> EXT, set Extended; other code -> RECEIVED; else stay.
REQ-021 EXT: NewScanCode & BREAK_CODE -> BRK; other code -> RECEIVED; Extended held.
REQ-022 BRK: next NewScanCode byte discarded -> SLEEP, clear Extended; no LoadDato, no push.
REQ-023 RECEIVED: LoadDato=1 exactly one cycle -> TYPE unconditionally.
REQ-024 TYPE: ScanCodeType=1 one cycle; NewAscii=1 -> NEW, capture {Extended, Ascii}; else -> SLEEP, clear Extended.
REQ-025 NEW: LoadChar=1 one cycle, push captured word -> SLEEP, clear Extended.
REQ-026 NewScanCode in RECEIVED, TYPE, NEW SHALL be ignored (dropped, no state effect).
REQ-027 Latency: make code to LoadChar = 3 cycles; CharData valid the cycle after push.
REQ-028 Pop when CharRead & !Empty; CharRead on Empty ignored, Count unchanged.
REQ-029 Push & pop same cycle: both performed, Count unchanged, including when Full.
REQ-030 Push when Full without pop: word dropped, Overflow set sticky until Reset.
REQ-031 Pointers SHALL wrap modulo FIFO_DEPTH; Full = Count==FIFO_DEPTH, Empty = Count==0.

Reset
REQ-032 Reset SHALL force SLEEP, Extended=0, Shift=0, Overflow=0, pointers and Count=0, Empty=1, Full=0.
REQ-033 Reset SHALL override all inputs including mid-sequence (BRK/EXT/NEW); pending push discarded; LoadDato, ScanCodeType, LoadChar=0 in reset cycle.

Configuration
REQ-034 Macro SCAN_CODE_SHIFT_TRACK_EN defined: make 8'h12 or 8'h59 sets Shift, codes still take RECEIVED path; break of same clears Shift in BRK; Shift = left OR right held.
REQ-035 Macro undefined: Shift tied 0, no shift-tracking registers, codes 8'h12/8'h59 processed as ordinary codes.

Verification
REQ-036 Make 8'h1C, NewAscii=1, Ascii=8'h61 -> LoadDato, ScanCodeType, LoadChar on cycles +1,+2,+3; CharData=9'h061, Count=1.
REQ-037 Sequence F0,1C -> no LoadDato, no push, state SLEEP after second byte.
REQ-038 Sequence E0,75 with Ascii=8'h80 -> CharData=9'h180; then E0,F0,75 -> no push, Extended=0.
REQ-039 FIFO_DEPTH=8: 9 pushes no reads -> Full=1, Count=8, Overflow=1, first 8 words intact; push+pop while Full -> Count stays 8.
REQ-040 Reset asserted in TYPE with NewAscii=1 -> no LoadChar, Empty=1, state SLEEP next cycle.
REQ-041 With SCAN_CODE_SHIFT_TRACK_EN: 12, 59, F0 12 -> Shift=1; F0 59 -> Shift=0.
